// File: rtl/mips_noc_ni.sv
// Memory-mapped NoC network interface for a MIPS node: CPU stores become
// HEAD+TAIL packets on the TX port, received packets queue up for CPU loads.

module mips_noc_ni_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // Fullness/emptiness are sampled before the edge, so a push into a full
  // FIFO is dropped even if a pop happens in the same cycle.
  assign push_ok = push && (count_q != FULL_CNT);
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

module mips_noc_ni #(
  parameter logic [3:0]  NODE_ID   = 4'd0,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_Write_M,
  input  logic        Mem_Read_M,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] Write_Data_M,
  output logic [31:0] mem_read_M,
  output logic        ni_hit,
  output logic        rx_pending,
  output logic        tx_flit_valid,
  output logic [33:0] tx_flit,
  input  logic        tx_flit_ready,
  input  logic        rx_flit_valid,
  input  logic [33:0] rx_flit,
  output logic        rx_flit_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;

  typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_TAIL} tx_state_e;
  typedef enum logic {RX_IDLE, RX_BODY} rx_state_e;

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [3:0] tx_dest_q, tx_dest_d;
  logic [3:0] rx_src_q, rx_src_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       rx_err_q, rx_err_d;

  logic [7:0]    off;
  logic          wr, rd;
  logic          tx_push, tx_pop, rx_push, rx_pop, rx_err_set;
  logic [35:0]   tx_head, rx_head;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_full, rx_full, rx_empty;
  logic [31:0]   status, rdata;

  assign ni_hit = (ALU_result_M[31:8] == BASE_ADDR[31:8]);
  assign off    = ALU_result_M[7:0];
  assign wr     = ni_hit && Mem_Write_M;
  assign rd     = ni_hit && Mem_Read_M;

  assign tx_push = wr && (off == 8'h04);
  assign tx_pop  = (tx_state_q == TX_TAIL) && tx_flit_ready;
  assign rx_pop  = rd && (off == 8'h0C);

  mips_noc_ni_fifo #(.W(36), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .wdata({tx_dest_q, Write_Data_M}), .head(tx_head), .count(tx_cnt)
  );

  mips_noc_ni_fifo #(.W(36), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .wdata({rx_src_q, rx_flit[31:0]}), .head(rx_head), .count(rx_cnt)
  );

  assign tx_full    = (tx_cnt == FULL_CNT);
  assign rx_full    = (rx_cnt == FULL_CNT);
  assign rx_empty   = (rx_cnt == '0);
  assign rx_pending = !rx_empty;

  // Serializer: flit is a pure function of state and FIFO head, so it is
  // stable while stalled and drops to zero the moment reset hits.
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_flit_valid = 1'b0;
    tx_flit       = '0;
    case (tx_state_q)
      TX_IDLE: if (tx_cnt != '0) tx_state_d = TX_HEAD;
      TX_HEAD: begin
        tx_flit_valid = 1'b1;
        tx_flit       = {FT_HEAD, 24'h0, NODE_ID, tx_head[35:32]};
        if (tx_flit_ready) tx_state_d = TX_TAIL;
      end
      TX_TAIL: begin
        tx_flit_valid = 1'b1;
        tx_flit       = {FT_TAIL, tx_head[31:0]};
        if (tx_flit_ready) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_src_d      = rx_src_q;
    rx_push       = 1'b0;
    rx_err_set    = 1'b0;
    rx_flit_ready = 1'b1;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_flit_valid) begin
          if (rx_flit[33:32] == FT_HEAD) begin
            rx_src_d   = rx_flit[7:4];
            rx_state_d = RX_BODY;
          end else begin
            rx_err_set = 1'b1;
          end
        end
      end
      RX_BODY: begin
        // Backpressure only bites here; HEADs never need FIFO space.
        rx_flit_ready = !rx_full;
        if (rx_flit_valid && !rx_full) begin
          case (rx_flit[33:32])
            FT_TAIL: begin
              rx_push    = 1'b1;
              rx_state_d = RX_IDLE;
            end
            FT_HEAD: begin
              rx_err_set = 1'b1;
              rx_src_d   = rx_flit[7:4];
            end
            default: begin
              rx_err_set = 1'b1;
              rx_state_d = RX_IDLE;
            end
          endcase
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Sticky bits: a set in the same cycle as CLEAR wins.
  always_comb begin
    tx_dest_d = tx_dest_q;
    tx_ovf_d  = tx_ovf_q;
    rx_err_d  = rx_err_q;
    if (wr && (off == 8'h00)) tx_dest_d = Write_Data_M[3:0];
    if (wr && (off == 8'h10)) begin
      if (Write_Data_M[0]) tx_ovf_d = 1'b0;
      if (Write_Data_M[1]) rx_err_d = 1'b0;
    end
    if (tx_push && tx_full) tx_ovf_d = 1'b1;
    if (rx_err_set)         rx_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_dest_q  <= '0;
      rx_src_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_dest_q  <= tx_dest_d;
      rx_src_q   <= rx_src_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign status = {20'h0, 4'(rx_cnt), (rx_empty ? 4'h0 : rx_head[35:32]),
                   rx_err_q, tx_ovf_q, rx_empty, tx_full};

  always_comb begin
    rdata = '0;
    case (off)
      8'h00:   rdata = {28'h0, tx_dest_q};
      8'h08:   rdata = status;
      8'h0C:   rdata = rx_empty ? 32'h0 : rx_head[31:0];
      default: rdata = '0;
    endcase
  end

  assign mem_read_M = rd ? rdata : 32'h0;
endmodule

// File: tb/tb_mips_noc_ni.sv
// Directed bench for mips_noc_ni: register-map vector table plus packet
// sequences on the TX/RX flit ports.

module tb_mips_noc_ni;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_Write_M, Mem_Read_M;
  logic [31:0] ALU_result_M, Write_Data_M;
  logic [31:0] mem_read_M;
  logic        ni_hit, rx_pending;
  logic        tx_flit_valid, tx_flit_ready;
  logic [33:0] tx_flit;
  logic        rx_flit_valid, rx_flit_ready;
  logic [33:0] rx_flit;

  int n_chk  = 0;
  int n_fail = 0;

  mips_noc_ni #(.NODE_ID(4'd0), .BASE_ADDR(BASE), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .Mem_Write_M(Mem_Write_M), .Mem_Read_M(Mem_Read_M),
    .ALU_result_M(ALU_result_M), .Write_Data_M(Write_Data_M),
    .mem_read_M(mem_read_M), .ni_hit(ni_hit), .rx_pending(rx_pending),
    .tx_flit_valid(tx_flit_valid), .tx_flit(tx_flit), .tx_flit_ready(tx_flit_ready),
    .rx_flit_valid(rx_flit_valid), .rx_flit(rx_flit), .rx_flit_ready(rx_flit_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] off, input logic [31:0] data);
    ALU_result_M = {BASE[31:8], off};
    Write_Data_M = data;
    Mem_Write_M  = 1'b1;
    Mem_Read_M   = 1'b0;
    step();
    Mem_Write_M  = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    ALU_result_M = {BASE[31:8], off};
    Mem_Read_M   = 1'b1;
    Mem_Write_M  = 1'b0;
    #1;
    chk(name, mem_read_M, exp);
    step();
    Mem_Read_M   = 1'b0;
  endtask

  function automatic logic [33:0] fhead(input logic [3:0] src);
    return {2'b01, 24'h0, src, 4'h0};
  endfunction

  function automatic logic [33:0] ftail(input logic [31:0] d);
    return {2'b10, d};
  endfunction

  task automatic rx_send(input logic [33:0] f, input logic exp_ready, input string name);
    rx_flit_valid = 1'b1;
    rx_flit       = f;
    #1;
    chk(name, rx_flit_ready, exp_ready);
    step();
    rx_flit_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] exp_f[8];
    int got;

    rst = 1'b1;
    Mem_Write_M = 0; Mem_Read_M = 0;
    ALU_result_M = BASE + 32'h8; Write_Data_M = 0;
    tx_flit_ready = 0; rx_flit_valid = 0; rx_flit = '0;
    step();
    step();
    chk("rst tx_valid", tx_flit_valid, 1'b0);
    chk("rst tx_flit", tx_flit, 34'h0);
    chk("rst rx_ready", rx_flit_ready, 1'b1);
    chk("rst rx_pending", rx_pending, 1'b0);
    chk("rst mem_read", mem_read_M, 32'h0);
    chk("rst ni_hit", ni_hit, 1'b1);
    rst = 1'b0;
    step();

    // Register-map vectors
    vecs[0]  = '{BASE + 32'h08, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2};
    vecs[1]  = '{BASE + 32'h00, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
    vecs[2]  = '{BASE + 32'h00, 1'b1, 1'b0, 32'hFFFF_FFF3, 1'b1, 32'h0};
    vecs[3]  = '{BASE + 32'h00, 1'b0, 1'b1, 32'h0,         1'b1, 32'h3};
    vecs[4]  = '{BASE + 32'h00, 1'b1, 1'b1, 32'h7,         1'b1, 32'h3};
    vecs[5]  = '{BASE + 32'h00, 1'b0, 1'b1, 32'h0,         1'b1, 32'h7};
    vecs[6]  = '{BASE + 32'h0C, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{BASE + 32'h04, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{BASE + 32'h14, 1'b1, 1'b1, 32'hFFFF,      1'b1, 32'h0};
    vecs[9]  = '{32'h0000_0008, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0};
    vecs[10] = '{32'hFFFF_FE00, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0};
    vecs[11] = '{BASE + 32'h10, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
    vecs[12] = '{BASE + 32'h08, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[13] = '{BASE + 32'h00, 1'b1, 1'b0, 32'h5,         1'b1, 32'h0};
    vecs[14] = '{BASE + 32'h08, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2};
    for (int i = 0; i < 15; i++) begin
      ALU_result_M = vecs[i].addr;
      Mem_Write_M  = vecs[i].wr;
      Mem_Read_M   = vecs[i].rd;
      Write_Data_M = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d hit", i), ni_hit, vecs[i].exp_hit);
      chk($sformatf("vec%0d rdata", i), mem_read_M, vecs[i].exp_rd);
      step();
    end
    Mem_Write_M = 0; Mem_Read_M = 0;
    chk("no flit from reg accesses", tx_flit_valid, 1'b0);

    // Single TX packet, latency N+2 / N+3
    tx_flit_ready = 1'b1;
    ALU_result_M = BASE + 32'h04; Write_Data_M = 32'hDEAD_BEEF; Mem_Write_M = 1'b1;
    #1;
    chk("txA cycle N valid", tx_flit_valid, 1'b0);
    step();
    Mem_Write_M = 1'b0;
    #1;
    chk("txA N+1 valid", tx_flit_valid, 1'b0);
    step();
    chk("txA N+2 valid", tx_flit_valid, 1'b1);
    chk("txA N+2 head", tx_flit, 34'h1_0000_0005);
    step();
    chk("txA N+3 valid", tx_flit_valid, 1'b1);
    chk("txA N+3 tail", tx_flit, 34'h2_DEAD_BEEF);
    step();
    chk("txA N+4 valid", tx_flit_valid, 1'b0);

    // Overflow with ready held low, then drain
    tx_flit_ready = 1'b0;
    for (int i = 0; i < 5; i++) cpu_wr(8'h04, 32'hA000_0000 + i);
    chk("txB stall valid", tx_flit_valid, 1'b1);
    chk("txB stall head", tx_flit, 34'h1_0000_0005);
    step();
    chk("txB head stable", tx_flit, 34'h1_0000_0005);
    cpu_rd(8'h08, 32'h7, "txB status full+ovf");
    for (int i = 0; i < 4; i++) begin
      exp_f[2*i]   = 34'h1_0000_0005;
      exp_f[2*i+1] = {2'b10, 32'hA000_0000 + i};
    end
    tx_flit_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (tx_flit_valid) begin
        if (got < 8) chk($sformatf("txB flit%0d", got), tx_flit, exp_f[got]);
        got++;
      end
      step();
    end
    chk("txB flit count", got, 8);
    cpu_rd(8'h08, 32'h6, "txB ovf sticky");
    cpu_wr(8'h10, 32'h1);
    cpu_rd(8'h08, 32'h2, "txB ovf cleared");

    // Single RX packet
    rx_send(fhead(4'd3), 1'b1, "rxC head ready");
    rx_send(ftail(32'h1234), 1'b1, "rxC tail ready");
    chk("rxC pending", rx_pending, 1'b1);
    cpu_rd(8'h08, 32'h130, "rxC status");
    cpu_rd(8'h0C, 32'h1234, "rxC data");
    cpu_rd(8'h08, 32'h2, "rxC empty after pop");
    chk("rxC pending cleared", rx_pending, 1'b0);

    // RX full backpressure
    for (int i = 0; i < 4; i++) begin
      rx_send(fhead(4'(i + 1)), 1'b1, "rxD fill head");
      rx_send(ftail(32'hB0 + i), 1'b1, "rxD fill tail");
    end
    cpu_rd(8'h08, 32'h410, "rxD status full");
    rx_send(fhead(4'd9), 1'b1, "rxD 5th head accepted");
    rx_flit_valid = 1'b1; rx_flit = ftail(32'hC5);
    #1;
    chk("rxD tail blocked", rx_flit_ready, 1'b0);
    step();
    chk("rxD tail still blocked", rx_flit_ready, 1'b0);
    ALU_result_M = BASE + 32'h0C; Mem_Read_M = 1'b1;
    #1;
    chk("rxD pop data", mem_read_M, 32'hB0);
    chk("rxD blocked during pop", rx_flit_ready, 1'b0);
    step();
    Mem_Read_M = 1'b0;
    #1;
    chk("rxD tail ready after pop", rx_flit_ready, 1'b1);
    step();
    rx_flit_valid = 1'b0;
    cpu_rd(8'h08, 32'h420, "rxD status refilled");
    cpu_rd(8'h0C, 32'hB1, "rxD drain1");
    cpu_rd(8'h0C, 32'hB2, "rxD drain2");
    cpu_rd(8'h0C, 32'hB3, "rxD drain3");
    cpu_rd(8'h0C, 32'hC5, "rxD drain4");
    cpu_rd(8'h08, 32'h2, "rxD empty");

    // RX protocol errors
    rx_send(ftail(32'h5555), 1'b1, "rxE stray tail");
    rx_send(fhead(4'd6), 1'b1, "rxE head1");
    rx_send(fhead(4'd7), 1'b1, "rxE head2");
    rx_send(ftail(32'h7777), 1'b1, "rxE tail");
    cpu_rd(8'h08, 32'h178, "rxE status err");
    cpu_rd(8'h0C, 32'h7777, "rxE data");
    cpu_wr(8'h10, 32'h2);
    cpu_rd(8'h08, 32'h2, "rxE err cleared");
    rx_flit_valid = 1'b1; rx_flit = ftail(32'h1);
    ALU_result_M = BASE + 32'h10; Write_Data_M = 32'h2; Mem_Write_M = 1'b1;
    step();
    rx_flit_valid = 1'b0; Mem_Write_M = 1'b0;
    cpu_rd(8'h08, 32'hA, "rxE set beats clear");
    cpu_wr(8'h10, 32'h2);
    rx_send(fhead(4'd4), 1'b1, "rxE head before bad");
    rx_send({2'b11, 32'h0}, 1'b1, "rxE bad type");
    rx_send(ftail(32'h8888), 1'b1, "rxE tail after bad");
    cpu_rd(8'h08, 32'hA, "rxE bad type to idle");
    cpu_wr(8'h10, 32'h2);

    // Reset mid-packet on both ports
    tx_flit_ready = 1'b0;
    cpu_wr(8'h04, 32'hCAFE);
    step();
    chk("rstF tx head up", tx_flit_valid, 1'b1);
    rx_send(fhead(4'd5), 1'b1, "rstF rx head");
    rst = 1'b1;
    #1;
    chk("rstF tx_valid", tx_flit_valid, 1'b0);
    chk("rstF tx_flit", tx_flit, 34'h0);
    chk("rstF rx_ready", rx_flit_ready, 1'b1);
    step();
    rst = 1'b0;
    tx_flit_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rstF no tx after reset", tx_flit_valid, 1'b0);
      step();
    end
    rx_send(ftail(32'h99), 1'b1, "rstF stray tail");
    cpu_rd(8'h08, 32'hA, "rstF status");
    chk("rstF rx_pending", rx_pending, 1'b0);
    cpu_rd(8'h00, 32'h0, "rstF tx_dest reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
